input_conditioner: RTL

//  Front-end for the lab board inputs: synchronises and debounces the active-low push-keys and the

---
 rtl/input_conditioner_pkg.sv | 15 +
 rtl/input_conditioner_if.sv | 29 ++
 rtl/input_conditioner_debounce_fsm.sv | 93 +++++++++
 rtl/input_conditioner.sv | 75 +++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types for the board input conditioner.
// Key FSM state encoding and key index constants.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int KEY_RUN    = 0;
  localparam int KEY_CLR_LD = 1;

endpackage

// File: rtl/input_conditioner_if.sv
// Board-side bundle of the input conditioner.
// master: board/bench drives raw KEY_N, S; slave: conditioner drives the clean outputs.
interface input_conditioner_if #(
  parameter int NUM_KEYS = 2,
  parameter int S_WIDTH  = 8
);

  logic [NUM_KEYS-1:0] KEY_N;
  logic [S_WIDTH-1:0]  S;
  logic                SYS_RESET;
  logic [NUM_KEYS-1:0] KEY_LEVEL;
  logic [NUM_KEYS-1:0] KEY_PRESS;
  logic [NUM_KEYS-1:0] KEY_RELEASE;
  logic [S_WIDTH-1:0]  S_SYNC;
  logic                S_CHANGED;

  modport master (
    output KEY_N, S,
    input  SYS_RESET, KEY_LEVEL, KEY_PRESS,
    input  KEY_RELEASE, S_SYNC, S_CHANGED
  );

  modport slave (
    input  KEY_N, S,
    output SYS_RESET, KEY_LEVEL, KEY_PRESS,
    output KEY_RELEASE, S_SYNC, S_CHANGED
  );

endinterface

// File: rtl/input_conditioner_debounce_fsm.sv
// One push-key: 2-flop sync, debounce FSM, registered level/press/release.
// Ports: clk, rst_n, key_n_i (raw active-low), level_o, press_o, release_o.
module debounce_fsm
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  key_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          key_s;

  // Sync flops idle at 1 (released); key_s is 1 while pressed.
  assign key_s = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!key_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input front-end: reset sync, per-key debounce, switch sync.
// Ports: CLK, RESET (async active-low), bus (slave: raw keys/switches in, clean signals out).
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int S_WIDTH         = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input_conditioner_if.slave   bus
);

  if (DEBOUNCE_CYCLES < 1) begin : g_chk
    $fatal(1, "DEBOUNCE_CYCLES must be >= 1");
  end

  // Reset sync: asserts at once, releases on the 2nd edge.
  logic [1:0] rst_sync_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign bus.SYS_RESET = rst_sync_q[1];

  logic [S_WIDTH-1:0] s_meta_q;
  logic [S_WIDTH-1:0] s_sync_q;
  logic [S_WIDTH-1:0] s_prev_q;
  logic               s_chg_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s_meta_q <= '0;
      s_sync_q <= '0;
      s_prev_q <= '0;
      s_chg_q  <= 1'b0;
    end else begin
      s_meta_q <= bus.S;
      s_sync_q <= s_meta_q;
      s_prev_q <= s_sync_q;
      s_chg_q  <= (s_sync_q != s_prev_q);
    end
  end

  assign bus.S_SYNC    = s_sync_q;
  assign bus.S_CHANGED = s_chg_q;

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (CLK),
      .rst_n     (RESET),
      .key_n_i   (bus.KEY_N[k]),
      .level_o   (key_level[k]),
      .press_o   (key_press[k]),
      .release_o (key_release[k])
    );
  end

  assign bus.KEY_LEVEL   = key_level;
  assign bus.KEY_PRESS   = key_press;
  assign bus.KEY_RELEASE = key_release;

endmodule
